// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder cell processes one bit pair per clock,
// LSB first, between a valid/ready operand handshake and a valid/ready result handshake.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s, fa_cout;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // State register plus datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_ADD;
      S_ADD:   if (last_bit)  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: operands load only at the accepting edge, then shift right.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE && in_valid) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      cnt_d   = '0;
    end else if (state_q == S_ADD) begin
      sum_d   = {fa_s, sum_q[WIDTH-1:1]};
      carry_d = fa_cout;
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q == S_ADD);
    out_valid = (state_q == S_DONE);
    sum       = sum_q;
    cout      = carry_q;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): latency, busy length, carries,
// backpressure, ignored mid-add operands and mid-operation reset.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int tests = 0;
  int fails = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
  endtask

  // Accept one operand pair, wait for the result, optionally hold backpressure,
  // then release. noise=1 drives a competing operand (a=0x12) during ADD and DONE.
  task automatic do_add(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic [W-1:0] exp_sum, input logic exp_cout,
                        input int hold, input bit noise);
    int n;
    int busy_cnt;
    check({tag, ".pre_in_ready"}, 32'(in_ready), 32'd1);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!out_valid && n < 40) begin
      if (busy) busy_cnt++;
      if (noise && n == 3) begin
        in_valid = 1'b1; a = 8'h12; b = 8'h00; cin = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"},  32'(n),        32'd8);
    check({tag, ".busy_len"}, 32'(busy_cnt), 32'd8);
    check({tag, ".sum"},      32'(sum),      32'(exp_sum));
    check({tag, ".cout"},     32'(cout),     32'(exp_cout));
    check({tag, ".done_rdy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_sum"},   32'(sum),       32'(exp_sum));
      check({tag, ".hold_cout"},  32'(cout),      32'(exp_cout));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check_idle({tag, ".after"});
    $display("[TB] %s a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", tag, av, bv, cv, sum, cout);
  endtask

  initial begin
    int seen;
    #2;
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.busy",      32'(busy),      32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.sum",       32'(sum),       32'd0);
    check("rst.cout",      32'(cout),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_add("zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    do_add("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    do_add("max",    8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 1'b0);
    do_add("alt",    8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 0, 1'b0);
    do_add("bp",     8'h7C, 8'h91, 1'b1, 8'h0E, 1'b1, 5, 1'b0);
    do_add("noise",  8'h30, 8'h03, 1'b0, 8'h33, 1'b0, 2, 1'b1);
    // The competing operand must not have been queued.
    @(negedge clk);
    check_idle("noise.not_queued");

    // Reset during ADD, around bit 4.
    a = 8'hF0; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst2.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst2.in_ready",  32'(in_ready),  32'd1);
    check("rst2.busy",      32'(busy),      32'd0);
    check("rst2.out_valid", 32'(out_valid), 32'd0);
    check("rst2.sum",       32'(sum),       32'd0);
    check("rst2.cout",      32'(cout),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    check("rst2.no_result", 32'(seen), 32'd0);
    $display("[TB] rst2 abort a=f0 b=0f -> no result presented");
    do_add("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
